// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request in flight at a time; responses return in order.
interface fetch_unit_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [DATA_WIDTH-1:0]  imem_req_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time and
// presents {pc, instruction} (or a NOP bubble) to the IF/ID register.
module fetch_unit #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [DATA_WIDTH-1:0]  redirect_pc,
    fetch_unit_if.master           imem,
    output logic                   fetch_valid,
    output logic [DATA_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instruction_out
);
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h13);
    localparam logic [DATA_WIDTH-1:0]  ALIGN_MASK = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_PRESENT
    } state_t;

    state_t                 r_state;
    logic                   r_req_valid;
    logic [DATA_WIDTH-1:0]  r_fetch_pc;
    logic [DATA_WIDTH-1:0]  r_req_pc;
    logic                   r_drop;
    logic                   r_fetch_valid;
    logic [DATA_WIDTH-1:0]  r_pc_out;
    logic [INSTR_WIDTH-1:0] r_instr_out;

    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  w_fetch_pc_next;
    logic [DATA_WIDTH-1:0]  w_req_pc_next;
    logic                   w_drop_next;
    logic                   w_fetch_valid_next;
    logic [DATA_WIDTH-1:0]  w_pc_out_next;
    logic [INSTR_WIDTH-1:0] w_instr_out_next;
    logic                   w_accept;
    logic [DATA_WIDTH-1:0]  w_redirect_target;

    assign w_accept          = r_req_valid & imem.imem_req_ready;
    assign w_redirect_target = redirect_pc & ALIGN_MASK;

    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_req_pc_next      = r_req_pc;
        w_drop_next        = r_drop;
        w_fetch_valid_next = r_fetch_valid;
        w_pc_out_next      = r_pc_out;
        w_instr_out_next   = r_instr_out;

        case (r_state)
            ST_REQ: begin
                if (redirect_valid) begin
                    w_fetch_pc_next = w_redirect_target;
                    // Memory already took the old address; its response must be thrown away.
                    if (w_accept) begin
                        w_drop_next  = 1'b1;
                        w_state_next = ST_WAIT;
                    end
                end else if (w_accept) begin
                    w_req_pc_next = r_fetch_pc;
                    w_state_next  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    w_fetch_pc_next = w_redirect_target;
                    if (imem.imem_resp_valid) begin
                        w_drop_next  = 1'b0;
                        w_state_next = ST_REQ;
                    end else begin
                        w_drop_next = 1'b1;
                    end
                end else if (imem.imem_resp_valid) begin
                    if (r_drop) begin
                        w_drop_next  = 1'b0;
                        w_state_next = ST_REQ;
                    end else begin
                        w_fetch_valid_next = 1'b1;
                        w_pc_out_next      = r_req_pc;
                        w_instr_out_next   = imem.imem_resp_data;
                        w_fetch_pc_next    = r_req_pc + DATA_WIDTH'(4);
                        w_state_next       = ST_PRESENT;
                    end
                end
            end

            ST_PRESENT: begin
                if (redirect_valid || !stall) begin
                    if (redirect_valid) begin
                        w_fetch_pc_next = w_redirect_target;
                    end
                    w_fetch_valid_next = 1'b0;
                    w_pc_out_next      = '0;
                    w_instr_out_next   = NOP_INSTR;
                    w_state_next       = ST_REQ;
                end
            end

            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

    // Request valid is registered so it stays low throughout reset and rises one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_REQ;
            r_req_valid   <= 1'b0;
            r_fetch_pc    <= RESET_PC & ALIGN_MASK;
            r_req_pc      <= '0;
            r_drop        <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_pc_out      <= '0;
            r_instr_out   <= NOP_INSTR;
        end else begin
            r_state       <= w_state_next;
            r_req_valid   <= (w_state_next == ST_REQ);
            r_fetch_pc    <= w_fetch_pc_next;
            r_req_pc      <= w_req_pc_next;
            r_drop        <= w_drop_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_pc_out      <= w_pc_out_next;
            r_instr_out   <= w_instr_out_next;
        end
    end

    assign imem.imem_req_valid = r_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;
    assign fetch_valid         = r_fetch_valid;
    assign pc_out              = r_pc_out;
    assign instruction_out     = r_instr_out;
endmodule
